// File: rtl/conv_stream_padder.sv
// conv_stream_padder
//   Re-packs the channel-major 8-bit result stream of a conv/ReLU layer into a
//   zero-padded frame in the next layer's input buffer. Each stream sample is
//   written to its interior position of the padded frame. With the border path
//   enabled, a scan pointer also fills every border position with PAD_VALUE.
//   The host then does not have to reload data between chained layers.
//
//   Build option: define CONV_STREAM_PADDER_BORDER_EN to include the border scan.
//   Without it, only stream writes are issued and the border is expected to be
//   preloaded by the host.
//
// Ports
//   clk, rstn   clock, asynchronous active-low reset
//   start       one-cycle pulse that arms a frame (honoured only while idle)
//   in_data     stream byte
//   in_valid    stream qualifier (no backpressure)
//   out_data    buffer write data
//   out_we      buffer write enable
//   out_addr    buffer write address (padded-frame linear index)
//   busy        high while a frame is in progress
//   done        one-cycle pulse at frame completion
//   err         sticky; a sample arrived while idle or after the frame was full
module conv_stream_padder #(
  parameter int unsigned CHANNELS   = 128,
  parameter int unsigned OUT_WIDTH  = 28,
  parameter int unsigned OUT_HEIGHT = 28,
  parameter int unsigned PAD        = 1,
  parameter logic [7:0]  PAD_VALUE  = 8'd0,
  localparam int unsigned PW = OUT_WIDTH + 2 * PAD,
  localparam int unsigned PH = OUT_HEIGHT + 2 * PAD,
  localparam int unsigned AW = $clog2(CHANNELS * PH * PW)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic [7:0]    out_data,
  output logic          out_we,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned N    = CHANNELS * OUT_HEIGHT * OUT_WIDTH;
  localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned RowW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam int unsigned ColW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int unsigned CntW = $clog2(N + 1);

  localparam logic [CntW-1:0] NCnt    = CntW'(N);
  localparam logic [RowW-1:0] RowLast = RowW'(OUT_HEIGHT - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(OUT_WIDTH - 1);
  localparam logic [AW-1:0]   PlaneA  = AW'(PH * PW);
  localparam logic [AW-1:0]   PwA     = AW'(PW);
  localparam logic [AW-1:0]   PadA    = AW'(PAD);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [ChW-1:0]  ch_q;
  logic [RowW-1:0] row_q;
  logic [ColW-1:0] col_q;
  logic [7:0]      out_data_q;
  logic            out_we_q;
  logic [AW-1:0]   out_addr_q;
  logic            err_q;

  logic            frame_start;
  logic            accept;
  logic [AW-1:0]   stream_addr;
  logic            scan_done;
  logic            scan_wr;
  logic [AW-1:0]   scan_addr;

  assign frame_start = (state_q == StIdle) && start;
  // Samples are only taken while running and the frame is not yet full.
  assign accept      = in_valid && (state_q == StRun) && (cnt_q != NCnt);

  assign stream_addr = AW'(ch_q) * PlaneA + (AW'(row_q) + PadA) * PwA + AW'(col_q) + PadA;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if ((cnt_q == NCnt) && scan_done) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef CONV_STREAM_PADDER_BORDER_EN
  localparam int unsigned SrW = $clog2(PH);
  localparam int unsigned ScW = $clog2(PW);

  localparam logic [SrW-1:0] PadR    = SrW'(PAD);
  localparam logic [SrW-1:0] PadREnd = SrW'(PAD + OUT_HEIGHT);
  localparam logic [SrW-1:0] ScRLast = SrW'(PH - 1);
  localparam logic [ScW-1:0] PadC    = ScW'(PAD);
  localparam logic [ScW-1:0] PadCEnd = ScW'(PAD + OUT_WIDTH);
  localparam logic [ScW-1:0] ScCLast = ScW'(PW - 1);
  localparam logic [AW-1:0]  PosLast = AW'(CHANNELS * PH * PW - 1);

  logic [AW-1:0]  scan_ptr_q;
  logic [SrW-1:0] scan_r_q;
  logic [ScW-1:0] scan_c_q;
  logic           scan_done_q;
  logic           scan_step;
  logic           scan_border;

  // The stream owns the write port; the scan only moves on cycles it leaves free.
  assign scan_step   = (state_q == StRun) && !accept && !scan_done_q;
  assign scan_border = (scan_r_q < PadR) || (scan_r_q >= PadREnd) ||
                       (scan_c_q < PadC) || (scan_c_q >= PadCEnd);
  assign scan_wr     = scan_step && scan_border;
  assign scan_addr   = scan_ptr_q;
  assign scan_done   = scan_done_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scan_ptr_q  <= '0;
      scan_r_q    <= '0;
      scan_c_q    <= '0;
      scan_done_q <= 1'b0;
    end else if (frame_start) begin
      scan_ptr_q  <= '0;
      scan_r_q    <= '0;
      scan_c_q    <= '0;
      scan_done_q <= 1'b0;
    end else if (scan_step) begin
      // Pointer parks on the last position; the flag marks completion so the
      // pointer never needs to hold CHANNELS*PH*PW.
      if (scan_ptr_q == PosLast) begin
        scan_done_q <= 1'b1;
      end else begin
        scan_ptr_q <= scan_ptr_q + 1'b1;
      end
      if (scan_c_q == ScCLast) begin
        scan_c_q <= '0;
        scan_r_q <= (scan_r_q == ScRLast) ? '0 : scan_r_q + 1'b1;
      end else begin
        scan_c_q <= scan_c_q + 1'b1;
      end
    end
  end
`else
  assign scan_done = 1'b1;
  assign scan_wr   = 1'b0;
  assign scan_addr = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ch_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      out_data_q <= '0;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_q | (in_valid & ~accept);
      out_we_q <= accept | scan_wr;
      if (accept) begin
        out_addr_q <= stream_addr;
        out_data_q <= in_data;
      end else if (scan_wr) begin
        out_addr_q <= scan_addr;
        out_data_q <= PAD_VALUE;
      end
      if (frame_start) begin
        cnt_q <= '0;
        ch_q  <= '0;
        row_q <= '0;
        col_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
        if (col_q == ColLast) begin
          col_q <= '0;
          if (row_q == RowLast) begin
            row_q <= '0;
            ch_q  <= ch_q + 1'b1;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign out_data = out_data_q;
  assign out_we   = out_we_q;
  assign out_addr = out_addr_q;
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign err      = err_q;

endmodule

// File: tb/tb_conv_stream_padder.sv
module tb_conv_stream_padder;

  localparam int unsigned Ch    = 2;
  localparam int unsigned W     = 3;
  localparam int unsigned H     = 3;
  localparam int unsigned P     = 1;
  localparam int unsigned PW    = W + 2 * P;
  localparam int unsigned PH    = H + 2 * P;
  localparam int unsigned N     = Ch * W * H;
  localparam int unsigned Total = Ch * PH * PW;
  localparam int unsigned AW    = $clog2(Total);
  localparam logic [7:0]  PadVal = 8'hE7;
`ifdef CONV_STREAM_PADDER_BORDER_EN
  localparam bit BorderEn = 1'b1;
`else
  localparam bit BorderEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic [7:0]    out_data;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  conv_stream_padder #(
    .CHANNELS  (Ch),
    .OUT_WIDTH (W),
    .OUT_HEIGHT(H),
    .PAD       (P),
    .PAD_VALUE (PadVal)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .in_data (in_data),
    .in_valid(in_valid),
    .out_data(out_data),
    .out_we  (out_we),
    .out_addr(out_addr),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame progress as plain integers (0 idle, 1 run, 2 done).
  int         m_state;
  int         m_cnt;
  int         m_scan;
  bit         m_err;
  bit         m_we;
  int         m_addr;
  logic [7:0] m_data;

  int wr_cnt[Total];
  int done_pulses;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int stream_addr(input int k);
    int c, r, col;
    c   = k / (H * W);
    r   = (k / W) % H;
    col = k % W;
    return c * PH * PW + (r + P) * PW + col + P;
  endfunction

  function automatic bit is_border(input int p);
    int r, c;
    r = (p / PW) % PH;
    c = p % PW;
    return (r < P) || (r >= P + H) || (c < P) || (c >= P + W);
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_scan  = 0;
    m_err   = 1'b0;
    m_we    = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit v, input logic [7:0] d);
    int nxt;
    bit acc;
    bit scan_fin;
    nxt  = m_state;
    m_we = 1'b0;
    acc  = v && (m_state == 1) && (m_cnt < N);
    if (v && !acc) m_err = 1'b1;
    case (m_state)
      0: if (st) begin
        nxt    = 1;
        m_cnt  = 0;
        m_scan = 0;
      end
      1: begin
        scan_fin = !BorderEn || (m_scan == Total);
        if ((m_cnt == N) && scan_fin) nxt = 2;
        if (acc) begin
          m_we   = 1'b1;
          m_addr = stream_addr(m_cnt);
          m_data = d;
          m_cnt++;
        end else if (!scan_fin) begin
          if (is_border(m_scan)) begin
            m_we   = 1'b1;
            m_addr = m_scan;
            m_data = PadVal;
          end
          m_scan++;
        end
      end
      default: nxt = 0;
    endcase
    m_state = nxt;
  endtask

  task automatic step(input bit st, input bit v, input logic [7:0] d);
    start    = st;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_edge(st, v, d);
    #1;
    check_eq("we", {31'd0, out_we}, {31'd0, m_we});
    if (m_we) begin
      check_eq("addr", 32'(out_addr), 32'(m_addr));
      check_eq("data", {24'd0, out_data}, {24'd0, m_data});
    end
    check_eq("busy", {31'd0, busy}, {31'd0, m_state == 1});
    check_eq("done", {31'd0, done}, {31'd0, m_state == 2});
    check_eq("err", {31'd0, err}, {31'd0, m_err});
    if (out_we === 1'b1 && out_addr < AW'(Total)) wr_cnt[out_addr]++;
    if (done === 1'b1) done_pulses++;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_eq("rst_we", {31'd0, out_we}, 32'd0);
    check_eq("rst_addr", 32'(out_addr), 32'd0);
    check_eq("rst_data", {24'd0, out_data}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    rstn = 1'b1;
  endtask

  task automatic begin_frame();
    foreach (wr_cnt[i]) wr_cnt[i] = 0;
    done_pulses = 0;
    step(1'b1, 1'b0, 8'h00);
  endtask

  // Idles the stream until the model has passed through done back to idle.
  task automatic run_to_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (m_state == 2) seen = 1'b1;
      else if (seen) break;
    end
  endtask

  // Every interior address once; border addresses once only when the scan is built in.
  task automatic check_cover();
    for (int p = 0; p < Total; p++) begin
      check_eq("cover", 32'(wr_cnt[p]), (is_border(p) && !BorderEn) ? 32'd0 : 32'd1);
    end
    check_eq("done_pulses", 32'(done_pulses), 32'd1);
  endtask

  initial begin
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    model_reset();
    apply_reset();

    // Frame 1: long idle stretch first (border fills, or nothing happens), then samples.
    begin_frame();
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h5A);
    check_eq("first_addr", 32'(out_addr), 32'd6);
    check_eq("first_data", {24'd0, out_data}, 32'h5A);
    for (int k = 1; k < N - 1; k++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'($urandom));
    end
    step(1'b0, 1'b1, 8'hC3);
    check_eq("last_addr", 32'(out_addr), 32'd43);
    check_eq("last_data", {24'd0, out_data}, 32'hC3);
    run_to_done();
    check_cover();

    // Frame 2: a burst of N back-to-back samples in the middle of the scan.
    begin_frame();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < N; k++) step(1'b0, 1'b1, 8'($urandom));
    run_to_done();
    check_cover();

    // Frame 3: randomly spaced samples.
    begin_frame();
    for (int i = 0; i < 400 && m_cnt < N; i++) step(1'b0, 1'($urandom), 8'($urandom));
    run_to_done();
    check_cover();

    // Stray sample while idle sets err; it stays set, including across a start.
    step(1'b0, 1'b1, 8'h11);
    check_eq("err_set", {31'd0, err}, 32'd1);
    step(1'b0, 1'b0, 8'h00);
    begin_frame();
    check_eq("err_sticky", {31'd0, err}, 32'd1);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 8'($urandom));

    // Reset mid-frame abandons it; a sample before start flags err again.
    apply_reset();
    step(1'b0, 1'b1, 8'h22);
    check_eq("err_idle", {31'd0, err}, 32'd1);
    begin_frame();
    step(1'b0, 1'b1, 8'h3C);
    check_eq("restart_addr", 32'(out_addr), 32'd6);
    check_eq("restart_data", {24'd0, out_data}, 32'h3C);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
